// File: rtl/led_sequencer.sv
// LED register write-port owner: arbitrates processor LED writes against an
// autonomous prescaled pattern generator (rotate, count, blink).
module led_sequencer #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_write,
    input  logic                  cpu_sel_leds,
    input  logic                  cpu_sel_ctrl,
    input  logic [PRESCALE_W-1:0] period,
    output logic [7:0]            led_wdata,
    output logic                  led_write,
    output logic                  led_sel,
    output logic [2:0]            ctrl_q,
    output logic [7:0]            pattern_q
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    logic [2:0]            ctrl;
    logic [7:0]            pattern;
    logic [PRESCALE_W-1:0] cnt;
    logic                  pending;

    mode_e                 mode;
    logic                  running;
    logic [PRESCALE_W-1:0] last_cnt;
    logic                  tick;
    logic                  cpu_led_wr;
    logic                  ctrl_wr;
    logic [7:0]            nxt;

    assign mode       = mode_e'(ctrl[1:0]);
    assign running    = ctrl[2] && (mode != MODE_HOLD);
    assign cpu_led_wr = cpu_write & cpu_sel_leds;
    assign ctrl_wr    = cpu_write & cpu_sel_ctrl;

    // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign last_cnt = (period == '0) ? '0 : period - PRESCALE_W'(1);
    // >= rather than == so a period shortened mid-count cannot strand cnt above it.
    assign tick     = running && (cnt >= last_cnt);

    always_comb begin
        nxt = pattern;
        unique case (mode)
            MODE_HOLD:   nxt = pattern;
            MODE_ROTATE: nxt = {pattern[6:0], pattern[7]};
            MODE_COUNT:  nxt = pattern + 8'd1;
            MODE_BLINK:  nxt = pattern ^ 8'hFF;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= '0;
            pattern   <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            led_wdata <= '0;
            led_write <= 1'b0;
            led_sel   <= 1'b0;
        end else begin
            led_write <= 1'b0;
            led_sel   <= 1'b0;

            if (ctrl_wr)
                ctrl <= cpu_wdata[2:0];

            if (ctrl_wr || !running || tick)
                cnt <= '0;
            else
                cnt <= cnt + PRESCALE_W'(1);

            // Priority: CPU LED write, then a deferred tick, then a fresh tick.
            // A control write cancels generator activity in the same cycle.
            if (cpu_led_wr) begin
                pattern   <= cpu_wdata;
                led_wdata <= cpu_wdata;
                led_write <= 1'b1;
                led_sel   <= 1'b1;
                pending   <= ctrl_wr ? 1'b0 : (pending | tick);
            end else if (ctrl_wr) begin
                pending <= 1'b0;
            end else if (pending || tick) begin
                pattern   <= nxt;
                led_wdata <= nxt;
                led_write <= 1'b1;
                led_sel   <= 1'b1;
                pending   <= 1'b0;
            end
        end
    end

    assign ctrl_q    = ctrl;
    assign pattern_q = pattern;

endmodule
